// File: rtl/shift_pkg.sv
// Shared types and widths for the multi-cycle left shifter.
// Used by shift_left_sequential and sll_step.
package shift_pkg;

    localparam int unsigned SHIFT_W = 32;
    localparam int unsigned SHAMT_W = $clog2(SHIFT_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } shift_state_t;

endpackage

// File: rtl/sll_step.sv
// One zero-fill left-shift step: by one bit, or by four when stride4 is set.
// Purely combinational; the caller owns the data register.
module sll_step
    import shift_pkg::*;
#(
    parameter int unsigned W = SHIFT_W
) (
    input  logic [W-1:0] in,
    input  logic         stride4,
    output logic [W-1:0] out
);

    always_comb begin
        if (stride4) begin
            out = {in[W-5:0], 4'b0000};
        end else begin
            out = {in[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/shift_left_sequential.sv
// Multi-cycle logical left shifter with valid/ready on both sides.
// Define SHIFT_LEFT_STRIDE4_EN to shift four bits per cycle while count >= 4.
module shift_left_sequential
    import shift_pkg::*;
#(
    parameter int unsigned N = SHIFT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [N-1:0]         in,
    input  logic [$clog2(N)-1:0] shamt,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [N-1:0]         out,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] FOUR = CW'(4);

    shift_state_t  state_q, state_d;
    logic [N-1:0]  data_q, data_d;
    logic [CW-1:0] count_q, count_d;
    logic          step4;
    logic [N-1:0]  step_out;

`ifdef SHIFT_LEFT_STRIDE4_EN
    assign step4 = (count_q >= FOUR);
`else
    assign step4 = 1'b0;
`endif

    sll_step #(
        .W(N)
    ) u_step (
        .in     (data_q),
        .stride4(step4),
        .out    (step_out)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    data_d  = in;
                    count_d = shamt;
                    state_d = (shamt == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Exit is decided on the post-step count, so count never wraps
                data_d  = step_out;
                count_d = count_q - (step4 ? FOUR : ONE);
                if (count_d == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (o_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign i_ready = (state_q == S_IDLE);
    assign o_valid = (state_q == S_DONE);
    assign busy    = (state_q != S_IDLE);
    assign out     = data_q;

endmodule

// File: tb/tb_shift_left_sequential.sv
// Directed and random checks for shift_left_sequential.
// Expected latency follows SHIFT_LEFT_STRIDE4_EN when it is defined.
module tb_shift_left_sequential;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] in_d;
    logic [4:0]  shamt;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] out;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    shift_left_sequential #(.N(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_valid(i_valid),
        .i_ready(i_ready),
        .in     (in_d),
        .shamt  (shamt),
        .o_valid(o_valid),
        .o_ready(o_ready),
        .out    (out),
        .busy   (busy)
    );

    function automatic int exp_lat(input int s);
`ifdef SHIFT_LEFT_STRIDE4_EN
        return s / 4 + s % 4 + 1;
`else
        return s + 1;
`endif
    endfunction

    // Present one operand for one edge, then scramble the inputs.
    task automatic accept(input logic [31:0] a, input logic [4:0] s);
        @(negedge clk);
        in_d = a;
        shamt = s;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        in_d = $urandom;
        shamt = 5'($urandom);
    endtask

    // Edges counted from the capture edge until o_valid, bounded.
    task automatic wait_valid(output int edges);
        edges = 1;
        while (!o_valid && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic consume;
        @(negedge clk);
        o_ready = 1'b1;
        @(posedge clk);
        #1;
        o_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (i_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_i_ready got %b want 1", i_ready);
        end
        vectors++;
        if (o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_o_valid got %b want 0", o_valid);
        end
        vectors++;
        if (out !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_out got %h want 0", out);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
    endtask

    task automatic test_basic;
        int e;
        accept(32'h0000_0001, 5'd5);
        wait_valid(e);
        vectors++;
        if (!o_valid || e != exp_lat(5)) begin
            miscompares++;
            $display("FAIL basic_latency got %0d want %0d", e, exp_lat(5));
        end
        vectors++;
        if (out !== 32'h0000_0020) begin
            miscompares++;
            $display("FAIL basic_out got %h want 00000020", out);
        end
        consume();
        vectors++;
        if (o_valid !== 1'b0 || i_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_release got ov=%b ir=%b want 0 1",
                     o_valid, i_ready);
        end
    endtask

    task automatic test_edges;
        int e;
        accept(32'h8000_0001, 5'd0);
        wait_valid(e);
        vectors++;
        if (!o_valid || e != 1) begin
            miscompares++;
            $display("FAIL zero_latency got %0d want 1", e);
        end
        vectors++;
        if (out !== 32'h8000_0001) begin
            miscompares++;
            $display("FAIL zero_out got %h want 80000001", out);
        end
        consume();
        accept(32'hFFFF_FFFF, 5'd31);
        wait_valid(e);
        vectors++;
        if (!o_valid || e != exp_lat(31)) begin
            miscompares++;
            $display("FAIL max_latency got %0d want %0d", e, exp_lat(31));
        end
        vectors++;
        if (out !== 32'h8000_0000) begin
            miscompares++;
            $display("FAIL max_out got %h want 80000000", out);
        end
        consume();
    endtask

    task automatic test_backpressure;
        int e;
        int bad;
        accept(32'h0000_00F0, 5'd3);
        wait_valid(e);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (!o_valid || out !== 32'h0000_0780) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL hold_stable got %0d bad cycles want 0 (out %h)",
                     bad, out);
        end
        consume();
    endtask

    task automatic test_busy_ignore;
        int e;
        accept(32'h0000_0001, 5'd20);
        @(negedge clk);
        in_d = 32'h0000_1234;
        shamt = 5'd1;
        i_valid = 1'b1;
        #1;
        vectors++;
        if (i_ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_flags got ir=%b busy=%b want 0 1",
                     i_ready, busy);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        wait_valid(e);
        vectors++;
        if (!o_valid || out !== 32'h0010_0000) begin
            miscompares++;
            $display("FAIL busy_ignore got %h want 00100000", out);
        end
        consume();
    endtask

    task automatic test_back_to_back;
        int e;
        accept(32'h0000_0003, 5'd4);
        wait_valid(e);
        @(negedge clk);
        o_ready = 1'b1;
        i_valid = 1'b1;
        in_d = 32'h0000_0005;
        shamt = 5'd1;
        @(posedge clk);
        #1;
        o_ready = 1'b0;
        vectors++;
        if (o_valid !== 1'b0 || busy !== 1'b0 || i_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL turnaround got ov=%b busy=%b ir=%b want 0 0 1",
                     o_valid, busy, i_ready);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        wait_valid(e);
        vectors++;
        if (!o_valid || out !== 32'h0000_000A || e != exp_lat(1)) begin
            miscompares++;
            $display("FAIL b2b_result got %h lat %0d want 0000000a lat %0d",
                     out, e, exp_lat(1));
        end
        consume();
    endtask

    task automatic test_reset_midop;
        int e;
        accept(32'hA5A5_A5A5, 5'd20);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (o_valid !== 1'b0 || out !== 32'h0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midop_reset got ov=%b out=%h busy=%b want 0 0 0",
                     o_valid, out, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        accept(32'h0000_0003, 5'd2);
        wait_valid(e);
        vectors++;
        if (!o_valid || out !== 32'h0000_000C) begin
            miscompares++;
            $display("FAIL midop_next got %h want 0000000c", out);
        end
        consume();
    endtask

    task automatic test_random;
        int e;
        int stall;
        int bad;
        logic [31:0] a;
        logic [4:0] s;
        logic [31:0] want;
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            a = $urandom;
            s = 5'($urandom_range(0, 31));
            want = a << s;
            accept(a, s);
            wait_valid(e);
            if (!o_valid || out !== want || e != exp_lat(int'(s))) begin
                bad++;
                if (bad < 5)
                    $display("FAIL rand_%0d in=%h sh=%0d got %h/%0d want %h/%0d",
                             k, a, s, out, e, want, exp_lat(int'(s)));
            end
            stall = $urandom_range(0, 3);
            for (int j = 0; j < stall; j++) begin
                @(posedge clk);
                #1;
                if (!o_valid || out !== want) bad++;
            end
            consume();
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL random_model got %0d bad want 0", bad);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        i_valid = 1'b0;
        in_d = '0;
        shamt = '0;
        o_ready = 1'b0;
        test_reset();
        test_basic();
        test_edges();
        test_backpressure();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
